// File: rtl/accumulator_8bits_if.sv
// Command/result handshake bundle for accumulator_8bits.
// master drives commands and result acceptance; slave is the accumulator.
interface accumulator_8bits_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] operand;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic [7:0] acc;
  logic       ovf_sticky;

  modport master (
    output in_valid, op, operand, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, acc, ovf_sticky
  );

  modport slave (
    input  in_valid, op, operand, out_ready,
    output in_ready, out_valid, out_data, out_ovf, acc, ovf_sticky
  );
endinterface

// File: rtl/accumulator_8bits.sv
// 8-bit signed accumulator with LOAD/ADD/SUB/CLEAR commands, optional saturation,
// a three-state IDLE/EXEC/RESP handshake and a sticky overflow flag.
module adder_subtractor_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       m,
  output logic [7:0] s,
  output logic       ovf
);
  logic [7:0] b_eff;

  // Subtraction as a + ~b + 1; overflow judged against the effective operand.
  assign b_eff = b ^ {8{m}};
  assign s     = a + b_eff + {7'b0, m};
  assign ovf   = (a[7] == b_eff[7]) && (s[7] != a[7]);
endmodule

module accumulator_8bits #(
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  accumulator_8bits_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0] state_q,      state_d;
  logic [1:0] op_q,         op_d;
  logic [7:0] operand_q,    operand_d;
  logic [7:0] acc_q,        acc_d;
  logic [7:0] out_data_q,   out_data_d;
  logic       out_ovf_q,    out_ovf_d;
  logic       ovf_sticky_q, ovf_sticky_d;

  logic [7:0] core_s;
  logic       core_ovf;
  logic [7:0] result;
  logic       result_ovf;

  adder_subtractor_8bits u_core (
    .a   (acc_q),
    .b   (operand_q),
    .m   (op_q == OP_SUB),
    .s   (core_s),
    .ovf (core_ovf)
  );

  always_comb begin
    result     = '0;
    result_ovf = 1'b0;
    case (op_q)
      OP_LOAD:  result = operand_q;
      OP_ADD,
      OP_SUB: begin
        result     = core_s;
        result_ovf = core_ovf;
        // Clamp direction follows the sign of the accumulator before the command.
        if (SATURATE && core_ovf) result = acc_q[7] ? 8'h80 : 8'h7F;
      end
      OP_CLEAR: result = '0;
      default:  result = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    operand_d    = operand_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_ovf_d    = out_ovf_q;
    ovf_sticky_d = ovf_sticky_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d      = bus.op;
          operand_d = bus.operand;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        acc_d      = result;
        out_data_d = result;
        out_ovf_d  = result_ovf;
        if (op_q == OP_CLEAR) ovf_sticky_d = 1'b0;
        else                  ovf_sticky_d = ovf_sticky_q | result_ovf;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      operand_q    <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      operand_q    <= operand_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == RESP);
  assign bus.out_data   = out_data_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.acc        = acc_q;
  assign bus.ovf_sticky = ovf_sticky_q;
endmodule

// File: tb/tb_accumulator_8bits.sv
// Directed bench for accumulator_8bits: wrapping and saturating instances run in lockstep.
module tb_accumulator_8bits;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  accumulator_8bits_if if0 ();
  accumulator_8bits_if if1 ();

  accumulator_8bits #(.SATURATE(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if0));
  accumulator_8bits #(.SATURATE(1'b1)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] b);
    if0.in_valid = v; if0.op = op; if0.operand = b;
    if1.in_valid = v; if1.op = op; if1.operand = b;
  endtask

  task automatic set_ready(input logic r);
    if0.out_ready = r;
    if1.out_ready = r;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/acc"},    if0.acc,        8'h00);
    chk({tag, "/data"},   if0.out_data,   8'h00);
    chk({tag, "/ovf"},    if0.out_ovf,    1'b0);
    chk({tag, "/sticky"}, if0.ovf_sticky, 1'b0);
    chk({tag, "/valid"},  if0.out_valid,  1'b0);
    chk({tag, "/ready"},  if0.in_ready,   1'b1);
    chk({tag, "/acc1"},   if1.acc,        8'h00);
  endtask

  // One full command with out_ready high: accept, EXEC, RESP, back to IDLE.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] b,
                         input logic [7:0] e0, input logic [7:0] e1, input logic eovf,
                         input logic es0, input logic es1);
    @(negedge clk);
    chk({tag, "/in_ready"}, if0.in_ready, 1'b1);
    drive(1'b1, op, b);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00);
    chk({tag, "/exec_valid"}, if0.out_valid, 1'b0);
    chk({tag, "/exec_ready"}, if0.in_ready, 1'b0);
    @(posedge clk); #1;
    chk({tag, "/valid"},   if0.out_valid,  1'b1);
    chk({tag, "/data0"},   if0.out_data,   e0);
    chk({tag, "/acc0"},    if0.acc,        e0);
    chk({tag, "/ovf0"},    if0.out_ovf,    eovf);
    chk({tag, "/sticky0"}, if0.ovf_sticky, es0);
    chk({tag, "/data1"},   if1.out_data,   e1);
    chk({tag, "/acc1"},    if1.acc,        e1);
    chk({tag, "/ovf1"},    if1.out_ovf,    eovf);
    chk({tag, "/sticky1"}, if1.ovf_sticky, es1);
    @(posedge clk); #1;
    chk({tag, "/idle_valid"}, if0.out_valid, 1'b0);
  endtask

  initial begin
    drive(1'b0, 2'b00, 8'h00);
    set_ready(1'b1);
    #1;
    chk_reset_vals("reset");
    #12;
    @(negedge clk) rst_n = 1'b1;

    //       tag         op     B      wrap   sat    ovf   st0   st1
    run_cmd("ld_ff",    2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_cmd("add_wrap", 2'b01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_cmd("ld_7f",    2'b00, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_cmd("add_ovf",  2'b01, 8'h01, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b1);
    run_cmd("ld_80",    2'b00, 8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
    run_cmd("sub_ovf",  2'b10, 8'h01, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b1);
    run_cmd("clear",    2'b11, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_cmd("ld_6c",    2'b00, 8'h6C, 8'h6C, 8'h6C, 1'b0, 1'b0, 1'b0);
    run_cmd("sub_ca",   2'b10, 8'hCA, 8'hA2, 8'h7F, 1'b1, 1'b1, 1'b1);
    run_cmd("ld_55",    2'b00, 8'h55, 8'h55, 8'h55, 1'b0, 1'b1, 1'b1);
    run_cmd("add_aa",   2'b01, 8'hAA, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    run_cmd("clear2",   2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Backpressure: LOAD 11 held in RESP while a new ADD is offered.
    @(negedge clk);
    set_ready(1'b0);
    drive(1'b1, 2'b00, 8'h11);
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 8'h05);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp/valid",    if0.out_valid, 1'b1);
      chk("bp/data",     if0.out_data,  8'h11);
      chk("bp/in_ready", if0.in_ready,  1'b0);
      chk("bp/acc",      if0.acc,       8'h11);
      @(posedge clk); #1;
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    set_ready(1'b1);
    @(posedge clk); #1;
    chk("bp/release_valid", if0.out_valid, 1'b0);
    chk("bp/release_acc",   if0.acc,       8'h11);
    @(posedge clk); #1;
    chk("bp/no_latch", if0.in_ready, 1'b1);

    // Reset during EXEC drops the command.
    run_cmd("ld_40", 2'b00, 8'h40, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b01, 8'h01);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00);
    chk("rst/in_exec", if0.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst/no_valid", if0.out_valid, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    run_cmd("post_rst", 2'b01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
